// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: RV32I opcode constants, the ID/EX bubble encoding and the control bundle
package id_ex_stage_reg_pkg;
  localparam logic [6:0] ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] LOAD           = 7'b0000011;
  localparam logic [6:0] STORE          = 7'b0100011;
  localparam logic [6:0] JAL            = 7'b1101111;
  localparam logic [6:0] JALR           = 7'b1100111;
  localparam logic [6:0] BRANCH         = 7'b1100011;
  localparam logic [6:0] ECALL          = 7'b1110011;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       is_halted;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// load_use_detector: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detector
  import id_ex_stage_reg_pkg::*;
(
  input  logic [31:0] instruction_if_id,
  input  logic [31:0] instruction_id_ex,
  input  logic        mem_read_id_ex,
  input  logic        valid_id_ex,
  output logic        hazard
);
  logic [6:0] op;
  logic [4:0] rd_ex;
  logic       rs1_used;
  logic       rs2_used;
  always_comb begin
    op       = instruction_if_id[6:0];
    rd_ex    = instruction_id_ex[11:7];
    rs1_used = op inside {ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, JALR, BRANCH};
    rs2_used = op inside {ARITHMETIC, STORE, BRANCH};
    hazard   = mem_read_id_ex && valid_id_ex && rd_ex != 5'd0 &&
               ((rs1_used && instruction_if_id[19:15] == rd_ex) ||
                (rs2_used && instruction_if_id[24:20] == rd_ex));
  end
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use stall and bubble insertion
// ID_EX_PERF_COUNT_EN enables the saturating load-use bubble counter.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     instruction_if_id,
  input  logic [XLEN-1:0] pc_if_id,
  input  logic [XLEN-1:0] rs1_data_id,
  input  logic [XLEN-1:0] rs2_data_id,
  input  logic [XLEN-1:0] imm_id,
  input  logic            reg_write_id,
  input  logic            mem_read_id,
  input  logic            mem_write_id,
  input  logic            mem_to_reg_id,
  input  logic            alu_src_id,
  input  logic            is_halted_id,
  input  logic [1:0]      alu_op_id,
  input  logic            flush,
  output logic [31:0]     instruction_id_ex,
  output logic [XLEN-1:0] pc_id_ex,
  output logic [XLEN-1:0] rs1_data_id_ex,
  output logic [XLEN-1:0] rs2_data_id_ex,
  output logic [XLEN-1:0] imm_id_ex,
  output logic            reg_write_id_ex,
  output logic            mem_read_id_ex,
  output logic            mem_write_id_ex,
  output logic            mem_to_reg_id_ex,
  output logic            alu_src_id_ex,
  output logic            is_halted_id_ex,
  output logic [1:0]      alu_op_id_ex,
  output logic            valid_id_ex,
  output logic            stall,
  output logic [31:0]     bubble_count
);
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  ctrl_t           ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic            hazard;
  logic            bubble;
  load_use_detector u_det (
    .instruction_if_id (instruction_if_id),
    .instruction_id_ex (instr_q),
    .mem_read_id_ex    (ctrl_q.mem_read),
    .valid_id_ex       (valid_q),
    .hazard            (hazard)
  );
  always_comb begin
    bubble  = flush | hazard;
    stall   = hazard & ~flush;
    instr_d = bubble ? NOP_INSTR : instruction_if_id;
    ctrl_d  = bubble ? '0 : ctrl_t'{reg_write_id, mem_read_id, mem_write_id,
                                    mem_to_reg_id, alu_src_id, is_halted_id, alu_op_id};
    valid_d = ~bubble;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_if_id;
      rs1_q   <= rs1_data_id;
      rs2_q   <= rs2_data_id;
      imm_q   <= imm_id;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end
`ifdef ID_EX_PERF_COUNT_EN
  logic [31:0] bubble_count_q;
  always_ff @(posedge clk) begin
    if (!reset_n) bubble_count_q <= '0;
    else if (stall && bubble_count_q != 32'hFFFF_FFFF) bubble_count_q <= bubble_count_q + 32'd1;
  end
  assign bubble_count = bubble_count_q;
`else
  assign bubble_count = '0;
`endif
  assign instruction_id_ex = instr_q;
  assign pc_id_ex          = pc_q;
  assign rs1_data_id_ex    = rs1_q;
  assign rs2_data_id_ex    = rs2_q;
  assign imm_id_ex         = imm_q;
  assign reg_write_id_ex   = ctrl_q.reg_write;
  assign mem_read_id_ex    = ctrl_q.mem_read;
  assign mem_write_id_ex   = ctrl_q.mem_write;
  assign mem_to_reg_id_ex  = ctrl_q.mem_to_reg;
  assign alu_src_id_ex     = ctrl_q.alu_src;
  assign is_halted_id_ex   = ctrl_q.is_halted;
  assign alu_op_id_ex      = ctrl_q.alu_op;
  assign valid_id_ex       = valid_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: vector table with an expected-output scoreboard for id_ex_stage_reg
module tb_id_ex_stage_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW5    = 32'h0000_A283;
  localparam logic [31:0] ADD652 = 32'h0022_8333;
  localparam logic [31:0] ADDI67 = 32'h0013_8313;
  localparam logic [31:0] LW0    = 32'h0000_A003;
  localparam logic [31:0] ADD600 = 32'h0000_0333;
  localparam logic [31:0] JAL5   = 32'h0082_806F;
  localparam logic [31:0] SW5    = 32'h0051_2023;
  localparam logic [31:0] BEQ05  = 32'h0050_0063;
  localparam logic [31:0] ECALL5 = 32'h0002_8073;
  localparam logic [31:0] LUI5   = 32'h0028_02B7;
  localparam logic [31:0] LW6_5  = 32'h0002_A303;
  localparam logic [31:0] LW7_6  = 32'h0003_2383;
`ifdef ID_EX_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr, pc, rs1, rs2, imm;
  logic [7:0]  ctrl_in;
  logic        flush;
  logic [31:0] instr_o, pc_o, rs1_o, rs2_o, imm_o, bubble_count;
  logic        rw_o, mr_o, mw_o, m2r_o, as_o, halt_o, valid_o, stall;
  logic [1:0]  aluop_o;
  logic [7:0]  ctrl_o;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    logic [31:0] instr;
    bit          mr;
    bit          flush;
    bit          st;
  } vec_t;
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, imm;
    logic [7:0]  ctrl;
    bit          valid;
  } exp_t;
  vec_t        vecs[28];
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] exp_bc = 0;
  bit          bub;
  always #5 clk = ~clk;
  assign ctrl_o = {rw_o, mr_o, mw_o, m2r_o, as_o, halt_o, aluop_o};
  id_ex_stage_reg #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .instruction_if_id(instr), .pc_if_id(pc), .rs1_data_id(rs1), .rs2_data_id(rs2), .imm_id(imm),
    .reg_write_id(ctrl_in[7]), .mem_read_id(ctrl_in[6]), .mem_write_id(ctrl_in[5]),
    .mem_to_reg_id(ctrl_in[4]), .alu_src_id(ctrl_in[3]), .is_halted_id(ctrl_in[2]),
    .alu_op_id(ctrl_in[1:0]), .flush(flush),
    .instruction_id_ex(instr_o), .pc_id_ex(pc_o), .rs1_data_id_ex(rs1_o), .rs2_data_id_ex(rs2_o),
    .imm_id_ex(imm_o), .reg_write_id_ex(rw_o), .mem_read_id_ex(mr_o), .mem_write_id_ex(mw_o),
    .mem_to_reg_id_ex(m2r_o), .alu_src_id_ex(as_o), .is_halted_id_ex(halt_o), .alu_op_id_ex(aluop_o),
    .valid_id_ex(valid_o), .stall(stall), .bubble_count(bubble_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] i, input bit mr, input bit fl, input bit st);
    mk = '{i, mr, fl, st};
  endfunction
  initial begin
    vecs = '{
      mk(LW5, 1, 0, 0),    mk(ADD652, 0, 0, 1), mk(ADD652, 0, 0, 0), mk(LW5, 1, 0, 0),
      mk(ADDI67, 0, 0, 0), mk(LW0, 1, 0, 0),    mk(ADD600, 0, 0, 0), mk(LW5, 1, 0, 0),
      mk(JAL5, 0, 0, 0),   mk(LW5, 1, 0, 0),    mk(SW5, 0, 0, 1),    mk(SW5, 0, 0, 0),
      mk(LW5, 1, 0, 0),    mk(BEQ05, 0, 0, 1),  mk(BEQ05, 0, 0, 0),  mk(LW5, 1, 0, 0),
      mk(ECALL5, 0, 0, 0), mk(LW5, 1, 0, 0),    mk(LUI5, 0, 0, 0),   mk(LW5, 1, 0, 0),
      mk(ADD652, 0, 1, 0), mk(LW5, 1, 0, 0),    mk(LW6_5, 1, 0, 1),  mk(LW6_5, 1, 0, 0),
      mk(LW7_6, 1, 0, 1),  mk(LW7_6, 1, 0, 0),  mk(ADDI67, 0, 0, 1), mk(ADDI67, 0, 0, 0)
    };
    reset_n = 1'b0; flush = 1'b0; instr = '0; pc = '0; rs1 = '0; rs2 = '0; imm = '0; ctrl_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 0);
    chk("rst_rs1", rs1_o, 0);
    chk("rst_rs2", rs2_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_ctrl", 32'(ctrl_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bcount", bubble_count, 0);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      instr = vecs[i].instr; flush = vecs[i].flush;
      pc = $urandom; rs1 = $urandom; rs2 = $urandom; imm = $urandom;
      ctrl_in = 8'($urandom); ctrl_in[6] = vecs[i].mr;
      #1 chk($sformatf("stall[%0d]", i), 32'(stall), 32'(vecs[i].st));
      bub = vecs[i].st | vecs[i].flush;
      sb.push_back('{bub ? NOP : instr, pc, rs1, rs2, imm, bub ? 8'h00 : ctrl_in, !bub});
      if (vecs[i].st && PERF) exp_bc++;
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("instr[%0d]", i), instr_o, e.instr);
      chk($sformatf("ctrl[%0d]", i), 32'(ctrl_o), 32'(e.ctrl));
      chk($sformatf("valid[%0d]", i), 32'(valid_o), 32'(e.valid));
      chk($sformatf("bcount[%0d]", i), bubble_count, exp_bc);
      if (e.valid) begin
        chk($sformatf("pc[%0d]", i), pc_o, e.pc);
        chk($sformatf("rs1[%0d]", i), rs1_o, e.rs1);
        chk($sformatf("rs2[%0d]", i), rs2_o, e.rs2);
        chk($sformatf("imm[%0d]", i), imm_o, e.imm);
      end
    end
    @(negedge clk);
    instr = LW5; ctrl_in = 8'hFF; flush = 1'b0;
    @(negedge clk);
    instr = ADD652; ctrl_in = 8'h00;
    #1 chk("midrst_stall_before", 32'(stall), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(valid_o), 0);
    chk("midrst_instr", instr_o, NOP);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_ctrl", 32'(ctrl_o), 0);
    chk("midrst_bcount", bubble_count, 0);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("midrst_pc", pc_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
